// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a byte FIFO.
// Ports: sysclk/rst_n clock and sync reset, tx_data/tx_valid/tx_ready
// write side, uart_rxd_out serial line, busy, fifo_count queued bytes.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_rxd_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic wr_en;
    logic pop;
    logic baud_last;

    // Derived from registered count only; tx_valid never feeds tx_ready.
    assign tx_ready   = count < CW'(FIFO_DEPTH);
    assign wr_en      = tx_valid && tx_ready;
    assign baud_last  = baud_cnt == BW'(CLKS_PER_BIT - 1);
    // Pop looks at the registered count, so a byte written this
    // edge is never bypassed straight into the shifter.
    assign pop        = (count != '0) &&
                        ((state == IDLE) || ((state == STOP) && baud_last));
    assign fifo_count = count;

    always_ff @(posedge sysclk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // The line and busy are registered from the current state, so
    // each bit appears on the wire one cycle after its state cycle.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            uart_rxd_out <= 1'b1;
            busy         <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            busy <= (state != IDLE) || (count != '0);

            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            unique case (state)
                IDLE: begin
                    uart_rxd_out <= 1'b1;
                    baud_cnt     <= '0;
                    bit_idx      <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        state     <= START;
                    end
                end
                START: begin
                    uart_rxd_out <= 1'b0;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    uart_rxd_out <= shift_reg[bit_idx];
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    uart_rxd_out <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        // Back-to-back frames: no idle gap.
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: scoreboard of written bytes against
// frames decoded from the serial line by a cycle-exact monitor.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_rxd_out;
    logic       busy;
    logic [3:0] fifo_count;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .uart_rxd_out(uart_rxd_out),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_done = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Serial monitor: every bit must hold for exactly CPB samples.
    int         mon_ph = -1;
    logic [9:0] mon_bits;
    int         mon_bad;

    always @(negedge sysclk) begin
        if (!rst_n) begin
            mon_ph = -1;
        end else if (mon_ph < 0) begin
            if (uart_rxd_out === 1'b0) begin
                mon_ph   = 1;
                mon_bad  = 0;
                mon_bits = '0;
                start_q.push_back(cyc);
            end
        end else begin
            if (mon_ph % CPB == 0)
                mon_bits[mon_ph/CPB] = uart_rxd_out;
            else if (uart_rxd_out !== mon_bits[mon_ph/CPB])
                mon_bad++;
            mon_ph++;
            if (mon_ph == 10 * CPB) begin
                chk("frame_shape", 32'(mon_bad), 32'd0);
                chk("stop_bit", 32'(mon_bits[9]), 32'd1);
                if (exp_q.size() == 0)
                    chk("unexpected_frame", 32'(mon_bits[8:1]),
                        32'hFFFF_FFFF);
                else
                    chk("frame_byte", 32'(mon_bits[8:1]),
                        32'(exp_q.pop_front()));
                frames_done++;
                mon_ph = -1;
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        wait_cyc(c);
        @(negedge sysclk);
    endtask

    // One write attempt on the next edge; returns that edge's number.
    task automatic drive(input logic [7:0] d, input bit acc,
                         output int edge_c);
        @(negedge sysclk);
        tx_data  = d;
        tx_valid = 1'b1;
        chk("tx_ready", 32'(tx_ready), 32'(acc));
        if (acc) exp_q.push_back(d);
        @(posedge sysclk);
        #1;
        edge_c   = cyc;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        chk("frames_done", 32'(frames_done), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int e;
        int s0;
        int s1;
        int s2;
        int f;

        // Reset with tx_valid held high: nothing may be accepted.
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        rst_n    = 1'b0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_line", 32'(uart_rxd_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (5) @(negedge sysclk);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_frames", 32'(start_q.size()), 32'd0);

        // Single 0xA5 into idle block: latency and busy window.
        drive(8'hA5, 1'b1, n);
        chk("a5_count_n", 32'(fifo_count), 32'd1);
        at_neg(n + 1);
        chk("a5_count_n1", 32'(fifo_count), 32'd0);
        chk("a5_busy_n1", 32'(busy), 32'd1);
        chk("a5_line_n1", 32'(uart_rxd_out), 32'd1);
        at_neg(n + 2);
        chk("a5_line_n2", 32'(uart_rxd_out), 32'd0);
        at_neg(n + 41);
        chk("a5_busy_stop", 32'(busy), 32'd1);
        at_neg(n + 42);
        chk("a5_busy_end", 32'(busy), 32'd0);
        chk("a5_line_end", 32'(uart_rxd_out), 32'd1);
        wait_frames(1, 20);
        chk("a5_start", 32'(start_q.pop_front()), 32'(n + 2));

        // Back-to-back frames with zero gap.
        repeat (3) @(negedge sysclk);
        drive(8'h00, 1'b1, n);
        chk("b2b_count0", 32'(fifo_count), 32'd1);
        drive(8'hFF, 1'b1, e);
        chk("b2b_count1", 32'(fifo_count), 32'd1);
        drive(8'h55, 1'b1, e);
        chk("b2b_count2", 32'(fifo_count), 32'd2);
        wait_frames(4, 200);
        s0 = start_q.pop_front();
        s1 = start_q.pop_front();
        s2 = start_q.pop_front();
        chk("b2b_start0", 32'(s0), 32'(n + 2));
        chk("b2b_gap01", 32'(s1 - s0), 32'(10 * CPB));
        chk("b2b_gap12", 32'(s2 - s1), 32'(10 * CPB));

        // Burst of 12 writes: 9 accepted, then full.
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 12; i++) begin
            drive(8'(8'h10 + i), i < 9, e);
            if (i == 0) n = e;
        end
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ready", 32'(tx_ready), 32'd0);
        // Write on the STOP-to-START pop edge while full.
        wait_cyc(n + 40);
        drive(8'hEE, 1'b0, e);
        chk("pop_full_edge", 32'(e), 32'(n + 41));
        chk("pop_full_count", 32'(fifo_count), 32'd7);
        chk("pop_full_ready", 32'(tx_ready), 32'd1);
        wait_frames(13, 9 * 10 * CPB + 100);
        start_q.delete();

        // Reset during data bit 3 with 4 bytes queued.
        repeat (5) @(negedge sysclk);
        for (int i = 0; i < 5; i++) begin
            drive(8'(8'h81 + i), 1'b1, e);
            if (i == 0) n = e;
        end
        chk("pre_rst_count", 32'(fifo_count), 32'd4);
        at_neg(n + 19);
        rst_n = 1'b0;
        exp_q.delete();
        at_neg(n + 20);
        chk("mid_rst_line", 32'(uart_rxd_out), 32'd1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        f = frames_done;
        repeat (100) @(negedge sysclk);
        chk("no_frames_after_rst", 32'(frames_done), 32'(f));
        chk("idle_after_rst", 32'(uart_rxd_out), 32'd1);
        drive(8'h3C, 1'b1, e);
        wait_frames(f + 1, 10 * CPB + 20);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
